// File: rtl/note_detector.sv
// note_detector: measures the period of a square-wave tone and decodes it
// back to the 4-bit solfege switch code (inverse of the divider table).
// Optional hysteresis on the locked note: define NOTE_DET_HYST_EN.
// CLK_HZ sets the clock rate the nominal periods are derived from, so the
// same table can be retargeted (default 50 MHz).
module note_detector #(
  parameter int CNT_W      = 17,
  parameter int TOL        = 1000,
  parameter int STABLE_CNT = 4,
  parameter int MAX_PERIOD = 120000,
  parameter int CLK_HZ     = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic [3:0]       note,
  output logic             note_valid,
  output logic             new_note,
  output logic [CNT_W-1:0] period
);

  // Nominal periods: clock rate / tone frequency, truncated.
  localparam int NOM [8] = '{CLK_HZ/523, CLK_HZ/587, CLK_HZ/659, CLK_HZ/698,
                             CLK_HZ/783, CLK_HZ/880, CLK_HZ/987, CLK_HZ/1046};
  localparam logic [3:0] CODE [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b1001,
                                      4'b0111, 4'b1011, 4'b1101, 4'b1111};
  localparam logic [3:0]       STABLE_4 = 4'(STABLE_CNT);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, period_q;
  logic [3:0]       note_q, cand_q, run_q;
  logic [3:0]       cand_d, run_d, cls;
  logic             note_valid_q, new_note_q;
  logic             rise;
  int               cnt_i;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_comb sync_d = {sync_q[1:0], tone_in};

  // Synchronizer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // Classify the current count against every note window.
  always_comb begin
    cls   = 4'b0000;
    cnt_i = int'(cnt_q);
    for (int i = 0; i < 8; i++) begin
      if (cnt_i >= NOM[i] - TOL && cnt_i <= NOM[i] + TOL) cls = CODE[i];
    end
`ifdef NOTE_DET_HYST_EN
    // A locked note keeps a doubled window so a source near the edge does not dither.
    for (int i = 0; i < 8; i++) begin
      if (note_q != 4'b0000 && note_q == CODE[i] &&
          cnt_i >= NOM[i] - 2*TOL && cnt_i <= NOM[i] + 2*TOL) cls = CODE[i];
    end
`endif
  end

  // Next candidate / run length for the stability filter.
  always_comb begin
    cand_d = cls;
    run_d  = 4'd1;
    if (cls == cand_q) begin
      cand_d = cand_q;
      run_d  = (run_q >= STABLE_4) ? STABLE_4 : run_q + 4'd1;
    end
  end

  // Period measurement FSM with stability filter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      note_q       <= 4'b0000;
      note_valid_q <= 1'b0;
      new_note_q   <= 1'b0;
      cand_q       <= 4'b0000;
      run_q        <= 4'd0;
    end else begin
      new_note_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // First edge only arms the counter; no measurement yet.
          if (rise) begin
            cnt_q   <= ONE_C;
            state_q <= MEASURE;
          end else begin
            cnt_q <= '0;
          end
        end
        MEASURE: begin
          // An edge wins over a simultaneous timeout.
          if (rise) begin
            period_q <= cnt_q;
            cnt_q    <= ONE_C;
            cand_q   <= cand_d;
            run_q    <= run_d;
            if (run_d == STABLE_4 && cand_d != note_q) begin
              note_q       <= cand_d;
              note_valid_q <= |cand_d;
              new_note_q   <= 1'b1;
            end
          end else if (cnt_q == MAX_C) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            note_q       <= 4'b0000;
            note_valid_q <= 1'b0;
            cand_q       <= 4'b0000;
            run_q        <= 4'd0;
            new_note_q   <= |note_q;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign new_note   = new_note_q;
  assign period     = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector, run on a scaled clock (CLK_HZ=500k) so that each
// tone period is ~1000 clocks. Nominals: DO1 956 RE 851 MI 758 FA 716
// SOL 638 LA 568 SI 506 DO2 478; TOL=10, MAX_PERIOD=1200.
module tb_note_detector;
  localparam int CLK_HZ = 500_000;
  localparam int CNT_W  = 11;
  localparam int TOL    = 10;
  localparam int STABLE = 4;
  localparam int MAXP   = 1200;
  localparam int HZ [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};
  localparam logic [3:0] CODES [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b1001,
                                       4'b0111, 4'b1011, 4'b1101, 4'b1111};

  logic clk = 1'b0, reset = 1'b1, tone_in = 1'b0;
  logic [3:0] note;
  logic note_valid, new_note;
  logic [CNT_W-1:0] period;

  always #10 clk = ~clk;

  note_detector #(.CNT_W(CNT_W), .TOL(TOL), .STABLE_CNT(STABLE),
                  .MAX_PERIOD(MAXP), .CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in), .note(note),
    .note_valid(note_valid), .new_note(new_note), .period(period));

  int checks = 0, errors = 0, pulses = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timestamps of detected edges give the period; the last STABLE
  // classifications all equal (and different from the note) move the note.
  int         now, last_edge;
  bit         measuring, m1, m2, m3, m_rise;
  logic [3:0] e_note;
  bit         e_new;
  int         e_period;
  logic [3:0] hist[$];

  function automatic logic [3:0] classify(int p, logic [3:0] locked);
    logic [3:0] r = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      int nom = CLK_HZ / HZ[i];
      int tol = TOL;
      int d   = (p > nom) ? p - nom : nom - p;
`ifdef NOTE_DET_HYST_EN
      if (locked != 0 && locked == CODES[i]) tol = 2 * TOL;
`endif
      if (d <= tol && (r == 0 || locked == CODES[i])) r = CODES[i];
    end
    return r;
  endfunction

  task automatic model_measure(int p);
    bit same = 1;
    e_period = p;
    hist.push_back(classify(p, e_note));
    if (hist.size() > STABLE) void'(hist.pop_front());
    if (hist.size() == STABLE) begin
      foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
      if (same && hist[0] != e_note) begin
        e_note = hist[0];
        e_new  = 1;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      now = 0; last_edge = 0; measuring = 0; m1 = 0; m2 = 0; m3 = 0;
      e_note = 0; e_new = 0; e_period = 0; hist.delete();
    end else begin
      now++;
      e_new  = 0;
      m_rise = m2 && !m3;
      if (m_rise) begin
        if (measuring) model_measure(now - last_edge);
        measuring = 1;
        last_edge = now;
      end else if (measuring && now - last_edge == MAXP) begin
        measuring = 0;
        hist.delete();
        if (e_note != 0) e_new = 1;
        e_note = 0;
      end
      m3 = m2; m2 = m1; m1 = tone_in;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    #1;
    check("note", int'(note), int'(e_note));
    check("note_valid", int'(note_valid), int'(e_note != 0));
    check("new_note", int'(new_note), int'(e_new));
    check("period", int'(period), e_period);
  end

  always @(negedge clk) if (new_note) pulses++;

  // One or more square-wave periods, each starting with a rising edge.
  task automatic tone(int p, int n);
    for (int k = 0; k < n; k++) begin
      tone_in = 1'b1;
      repeat (p / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  initial begin
    #(2_000_000_000 / 1000);
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [3:0] exp_hyst;
    repeat (3) @(negedge clk);
    check("rst_note", int'(note), 0);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(note_valid), 0);
    reset = 1'b0;

    // DO1 with reset asserted mid-stream
    fork
      tone(956, 8);
      begin
        repeat (1500) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_note", int'(note), 0);
        check("midrst_period", int'(period), 0);
        check("midrst_new", int'(new_note), 0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
      end
    join
    check("do1_note", int'(note), 4'b0001);
    check("do1_valid", int'(note_valid), 1);
    check("do1_period", int'(period), 956);
    check("do1_pulses", pulses - p0, 1);

    // change to DO2
    p0 = pulses;
    tone(478, 5);
    check("do2_note", int'(note), 4'b1111);
    check("do2_pulses", pulses - p0, 1);

    // MI lock, then a single glitch period
    tone(758, 5);
    check("mi_note", int'(note), 4'b0101);
    p0 = pulses;
    tone(20, 1);
    tone(758, 5);
    check("glitch_note", int'(note), 4'b0101);
    check("glitch_pulses", pulses - p0, 0);

    // LA at the window edge, then just outside it
    tone(578, 5);
    check("la_edge_note", int'(note), 4'b1011);
    tone(579, 4);
    tone(588, 2);
`ifdef NOTE_DET_HYST_EN
    exp_hyst = 4'b1011;
`else
    exp_hyst = 4'b0000;
`endif
    check("la_out_note", int'(note), int'(exp_hyst));
    check("la_out_period", int'(period), 588);

    // SOL lock then silence
    tone(638, 6);
    check("sol_note", int'(note), 4'b0111);
    p0 = pulses;
    repeat (1300) @(negedge clk);
    check("sil_note", int'(note), 0);
    check("sil_valid", int'(note_valid), 0);
    check("sil_period", int'(period), 638);
    check("sil_pulses", pulses - p0, 1);

    // edge exactly at MAX_PERIOD is still measured
    tone(638, 1);
    tone(1200, 1);
    tone(638, 1);
    check("max_period", int'(period), 1200);
    repeat (1300) @(negedge clk);
    check("max_note", int'(note), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
